// File: rtl/l2_line_responder.sv
// l2_line_responder
//   L2-side responder for D$ line refill / writeback requests. A line request
//   is split into BEATS = LINE_BYTES*8/DATA_WIDTH word beats on a narrow
//   backing-memory bus. Read beats are reassembled into a line buffer, and the
//   finished line is returned to the D$ as a single-cycle l2_valid_o pulse.
//
//   Optional feature macro: L2_RESP_CRITICAL_WORD_FIRST_EN
//     defined   - beats start at the requested word and wrap within the line;
//                 an extra one-cycle l2_valid_o follows the first read beat
//     undefined - beats run 0..BEATS-1, only the final pulse is produced
//
//   Ports
//     clk_i, rst_ni               clock, async active-low reset
//     l2_ready_o                  high only when idle (request may be presented)
//     dcache_l2_req_*_i           D$ line request (valid, we, addr, wdata)
//     l2_valid_o/addr_o/data_o    completion pulse, line address, line data
//     mem_req_valid_o/ready_i     beat request handshake
//     mem_we_o/addr_o/wdata_o     beat direction, byte address, write data
//     mem_rvalid_i/rdata_i        in-order read beat return
module l2_line_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    l2_ready_o,
  input  logic                    dcache_l2_req_valid_i,
  input  logic                    dcache_l2_req_we_i,
  input  logic [ADDR_WIDTH-1:0]   dcache_l2_req_addr_i,
  input  logic [LINE_BYTES*8-1:0] dcache_l2_req_wdata_i,
  output logic                    l2_valid_o,
  output logic [ADDR_WIDTH-1:0]   l2_addr_o,
  output logic [LINE_BYTES*8-1:0] l2_data_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BEATS = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int unsigned WB_W  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [IDX_W-1:0]        start_q, start_d;
  logic [CNT_W-1:0]        issue_q, issue_d;
  logic [CNT_W-1:0]        ret_q, ret_d;
  logic [LINE_W-1:0]       line_q, line_d;
`ifdef L2_RESP_CRITICAL_WORD_FIRST_EN
  logic                    early_q, early_d;
`endif

  // Word slots wrap within the line by truncation to IDX_W bits.
  logic [IDX_W-1:0]        w_issue;
  logic [IDX_W-1:0]        w_ret;

  assign w_issue = start_q + issue_q[IDX_W-1:0];
  assign w_ret   = start_q + ret_q[IDX_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
      issue_q <= '0;
      ret_q   <= '0;
      line_q  <= '0;
`ifdef L2_RESP_CRITICAL_WORD_FIRST_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      line_q  <= line_d;
`ifdef L2_RESP_CRITICAL_WORD_FIRST_EN
      early_q <= early_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    issue_d = issue_q;
    ret_d   = ret_q;
    line_d  = line_q;
`ifdef L2_RESP_CRITICAL_WORD_FIRST_EN
    early_d    = 1'b0;
    l2_valid_o = early_q;
`else
    l2_valid_o = 1'b0;
`endif
    l2_ready_o      = 1'b0;
    l2_addr_o       = base_q;
    l2_data_o       = line_q;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;

    unique case (state_q)
      IDLE: begin
        l2_ready_o = 1'b1;
        if (dcache_l2_req_valid_i) begin
          base_d  = dcache_l2_req_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);
`ifdef L2_RESP_CRITICAL_WORD_FIRST_EN
          start_d = dcache_l2_req_addr_i[WB_W +: IDX_W];
`else
          start_d = '0;
`endif
          issue_d = '0;
          ret_d   = '0;
          if (dcache_l2_req_we_i) begin
            line_d  = dcache_l2_req_wdata_i;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: begin
        // Issue runs ahead of return; both counters may step in one cycle.
        mem_req_valid_o = (issue_q < CNT_W'(BEATS));
        mem_addr_o      = base_q + (ADDR_WIDTH'(w_issue) << WB_W);
        if (mem_req_valid_o && mem_req_ready_i) begin
          issue_d = issue_q + 1'b1;
        end
        if (mem_rvalid_i) begin
          line_d[w_ret * DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
          ret_d = ret_q + 1'b1;
`ifdef L2_RESP_CRITICAL_WORD_FIRST_EN
          if (ret_q == '0) begin
            early_d = 1'b1;
          end
`endif
          if (ret_q == CNT_W'(BEATS - 1)) begin
            state_d = RESP;
          end
        end
      end

      WRITE: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = base_q + (ADDR_WIDTH'(w_issue) << WB_W);
        mem_wdata_o     = line_q[w_issue * DATA_WIDTH +: DATA_WIDTH];
        if (mem_req_ready_i) begin
          issue_d = issue_q + 1'b1;
          if (issue_q == CNT_W'(BEATS - 1)) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        l2_valid_o = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
